// File: rtl/reg_delay_line.sv
`default_nettype none
// ============================================================================
//  Module   : reg_delay_line
//  Purpose  : Fixed-depth register delay line with per-stage valid bits,
//             a combinational tap selector, a valid-stage occupancy counter
//             and a "primed" flag that marks DEPTH enabled cycles since the
//             last reset or clear.
//  Ports    : CLK        - clock, all state changes on the rising edge
//             RST        - synchronous active-high reset (highest priority)
//             CLR        - synchronous flush (below RST, above EN)
//             EN         - advances the pipeline by one stage
//             D/D_VALID  - data and its valid qualifier into stage 0
//             TAP_SEL    - stage index driven on TAP_Q/TAP_VALID
//             Q/Q_VALID  - last stage, straight from registers
//             TAP_Q/TAP_VALID - selected stage (combinational)
//             FILL       - number of stages currently holding valid data
//             PRIMED     - high once DEPTH enabled cycles have elapsed
//  Revision : 1.0 - initial release
// ============================================================================
module reg_delay_line #(
  parameter int                WIDTH     = 8,
  parameter int                DEPTH     = 4,
  parameter logic [WIDTH-1:0]  RESET_VAL = {WIDTH{1'b0}},
  localparam int               TW        = $clog2(DEPTH),
  localparam int               FW        = $clog2(DEPTH + 1)
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             EN,
  input  logic             CLR,
  input  logic [WIDTH-1:0] D,
  input  logic             D_VALID,
  input  logic [TW-1:0]    TAP_SEL,
  output logic [WIDTH-1:0] Q,
  output logic             Q_VALID,
  output logic [WIDTH-1:0] TAP_Q,
  output logic             TAP_VALID,
  output logic [FW-1:0]    FILL,
  output logic             PRIMED
);

  localparam logic [FW-1:0] C_DEPTH = FW'(DEPTH);
  localparam logic [FW-1:0] C_ONE   = FW'(1);
  localparam logic [FW-1:0] C_ZERO  = '0;

  logic [WIDTH-1:0] s_q [DEPTH];
  logic [WIDTH-1:0] s_d [DEPTH];
  logic [DEPTH-1:0] v_q, v_d;
  logic [FW-1:0]    fill_q, fill_d;
  logic [FW-1:0]    cnt_q, cnt_d;
  logic             primed_q, primed_d;

  // Next-state logic; CLR overrides EN, RST is handled in the flop block.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      s_d[i] = s_q[i];
    end
    v_d      = v_q;
    fill_d   = fill_q;
    cnt_d    = cnt_q;
    primed_d = primed_q;

    if (CLR) begin
      for (int i = 0; i < DEPTH; i++) begin
        s_d[i] = RESET_VAL;
      end
      v_d      = '0;
      fill_d   = C_ZERO;
      cnt_d    = C_ZERO;
      primed_d = 1'b0;
    end else if (EN) begin
      s_d[0] = D;
      for (int i = 1; i < DEPTH; i++) begin
        s_d[i] = s_q[i-1];
      end
      v_d = {v_q[DEPTH-2:0], D_VALID};

      // Occupancy tracks the popcount incrementally: one valid may enter
      // at stage 0 and one may leave from the last stage on the same edge.
      case ({D_VALID, v_q[DEPTH-1]})
        2'b10:   fill_d = fill_q + C_ONE;
        2'b01:   fill_d = fill_q - C_ONE;
        default: fill_d = fill_q;
      endcase

      // Saturating count of enabled edges; PRIMED follows the next count so
      // it rises on the very edge the count reaches DEPTH.
      if (cnt_q != C_DEPTH) begin
        cnt_d = cnt_q + C_ONE;
      end
      primed_d = (cnt_d == C_DEPTH);
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int i = 0; i < DEPTH; i++) begin
        s_q[i] <= RESET_VAL;
      end
      v_q      <= '0;
      fill_q   <= C_ZERO;
      cnt_q    <= C_ZERO;
      primed_q <= 1'b0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        s_q[i] <= s_d[i];
      end
      v_q      <= v_d;
      fill_q   <= fill_d;
      cnt_q    <= cnt_d;
      primed_q <= primed_d;
    end
  end

  // Tap mux: selector values beyond the last stage (possible when DEPTH is
  // not a power of two) fall through to the reset value with valid low.
  always_comb begin
    TAP_Q     = RESET_VAL;
    TAP_VALID = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (TAP_SEL == TW'(i)) begin
        TAP_Q     = s_q[i];
        TAP_VALID = v_q[i];
      end
    end
  end

  assign Q       = s_q[DEPTH-1];
  assign Q_VALID = v_q[DEPTH-1];
  assign FILL    = fill_q;
  assign PRIMED  = primed_q;

endmodule
`default_nettype wire

// File: doc/reg_delay_line.md
REG_DELAY_LINE -- requirements
Module: reg_delay_line

Parameters
REQ-001 SHALL provide WIDTH, default 8: data width in bits, legal range 1..64.
REQ-002 SHALL provide DEPTH, default 4: number of register stages, legal range 2..32.
REQ-003 SHALL provide RESET_VAL, default {WIDTH{1'b0}}: data value loaded into every stage on reset and on clear.
REQ-004 SHALL size TW as $clog2(DEPTH) and FW as $clog2(DEPTH+1).

Interface
REQ-005 SHALL use one clock, and its reset SHALL be synchronous and active-high.
REQ-006 SHALL have port CLK, input, 1 bit: the clock; all state updates occur on its rising edge.
REQ-007 SHALL have port RST, input, 1 bit: synchronous active-high reset.
REQ-008 SHALL have port EN, input, 1 bit: advances the pipeline by one stage.
REQ-009 SHALL have port CLR, input, 1 bit: synchronous flush.
REQ-010 SHALL have port D, input, WIDTH bits: data into stage 0.
REQ-011 SHALL have port D_VALID, input, 1 bit: valid qualifier for D.
REQ-012 SHALL have port TAP_SEL, input, TW bits: selects the stage driven on TAP_Q.
REQ-013 SHALL have port Q, output, WIDTH bits: last stage (DEPTH-1).
REQ-014 SHALL have port Q_VALID, output, 1 bit: valid bit of the last stage.
REQ-015 SHALL have port TAP_Q, output, WIDTH bits: data of the stage selected by TAP_SEL.
REQ-016 SHALL have port TAP_VALID, output, 1 bit: valid bit of the selected stage.
REQ-017 SHALL have port FILL, output, FW bits: count of valid stages.
REQ-018 SHALL have port PRIMED, output, 1 bit: high once DEPTH EN cycles have elapsed since the last reset or clear.

Function
REQ-019 SHALL hold per-stage data registers s[0..DEPTH-1] and valid bits v[0..DEPTH-1].
REQ-020 SHALL, on an edge with EN=1, load s[0]<=D and v[0]<=D_VALID, and load s[i]<=s[i-1] and v[i]<=v[i-1] for i>=1.
REQ-021 SHALL, on an edge with EN=0, hold all stages, FILL and PRIMED unchanged.
REQ-022 SHALL deliver a word to Q exactly DEPTH EN-qualified edges after capture; stalls (EN=0) extend latency cycle-for-cycle.
REQ-023 SHALL drive Q=s[DEPTH-1] and Q_VALID=v[DEPTH-1] directly from registers.
REQ-024 SHALL drive TAP_Q and TAP_VALID combinationally from TAP_SEL.
REQ-025 SHALL, when TAP_SEL>=DEPTH (non-power-of-2 DEPTH), output TAP_Q=RESET_VAL and TAP_VALID=0.
REQ-026 SHALL register FILL so that it always equals the popcount of v[] as of the same edge: +1 when D_VALID enters and v[DEPTH-1] does not leave, -1 for the converse, unchanged otherwise.
REQ-027 SHALL register PRIMED from a saturating EN counter (0..DEPTH) and set PRIMED=1 when that counter reaches DEPTH, holding it at saturation.
REQ-028 SHALL, when CLR=1, set all s[] to RESET_VAL, all v[] to 0, FILL to 0, and the EN counter and PRIMED to 0, regardless of EN.
REQ-029 SHALL apply priority RST > CLR > EN.

Reset
REQ-030 SHALL, on an edge with RST=1, set s[]=RESET_VAL, v[]=0, Q=RESET_VAL, Q_VALID=0, FILL=0 and PRIMED=0.
REQ-031 SHALL apply reset mid-stream with the same effect, and SHALL present no data captured before reset at Q afterwards.
REQ-032 SHALL, on the first edge after RST deasserts with EN=1, capture D normally.

Verification (WIDTH=8, DEPTH=4, RESET_VAL=0)
REQ-033 SHALL cover streaming: EN=1 and D_VALID=1 with D=0x11,0x22,0x33,0x44,0x55 on consecutive edges -> Q=0x11 with Q_VALID=1 after the 4th edge, 0x22 after the 5th; FILL reads 1,2,3,4,4; PRIMED=1 after the 4th edge.
REQ-034 SHALL cover stall: 0xA5 captured, then EN=0 for 3 cycles, then EN=1 -> Q=0xA5 only on the 4th EN edge; FILL and Q hold during the stall.
REQ-035 SHALL cover bubbles: D_VALID pattern 1,0,1,0 with D=0x01..0x04 -> Q_VALID sequence 1,0,1,0 from the 4th edge; FILL peaks at 2.
REQ-036 SHALL cover tap: pipeline holding 0x11..0x44 and TAP_SEL=0..3 -> TAP_Q=0x44,0x33,0x22,0x11 with TAP_VALID=1, updating in the same cycle.
REQ-037 SHALL cover clear vs. enable: CLR=1 and EN=1 together with D=0xFF -> next cycle all stages 0, FILL=0, PRIMED=0; 0xFF is not captured.
REQ-038 SHALL cover reset vs. clear: RST=1 and CLR=1 with full pipeline -> reset values; then DEPTH=5 build with TAP_SEL=7 -> TAP_Q=0x00, TAP_VALID=0.
